// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak core arbiter.
package keccak_pkg;

  localparam int D_WIDTH   = 1600;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ABSORB,
    LAST,
    SQUEEZE,
    DONE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one lane-serial Keccak-f[1600] core between NUM_REQ requesters:
// grant round-robin, absorb 25 lanes, collect 25 squeezed lanes, pulse done.
//
// state   | meaning
// IDLE    | waiting for a request while the core is ready
// START   | one-cycle start pulse to the core
// ABSORB  | driving granted lanes 0..24
// LAST    | one-cycle last_block pulse
// SQUEEZE | capturing 25 valid output lanes into dout_o
// DONE    | done pulse to the granted requester, advance rr pointer
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*D_WIDTH-1:0] din_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [D_WIDTH-1:0]         dout_o,
  output logic                       busy_o,
  input  logic                       ready_keccak_i,
  output logic                       start_keccak_o,
  output logic [LANE_W-1:0]          din_keccak_o,
  output logic                       din_valid_keccak_o,
  output logic                       last_block_keccak_o,
  input  logic [LANE_W-1:0]          dout_keccak_i,
  input  logic                       dout_valid_keccak_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [4:0]         lane_cnt_q, lane_cnt_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  lane_t              dout_q [NUM_LANES];
  logic               dout_we;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      gnt_idx;
  lane_t              din_lanes [NUM_REQ][NUM_LANES];
  lane_t              sel_lane;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
      assign din_lanes[k][j] = din_i[k*D_WIDTH + j*LANE_W +: LANE_W];
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_dout
    assign dout_o[j*LANE_W +: LANE_W] = dout_q[j];
  end

  // One-hot grant drives an AND-OR lane mux; the index is only needed for rr_ptr.
  always_comb begin
    sel_lane = '0;
    gnt_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        sel_lane = sel_lane | din_lanes[k][lane_cnt_q];
        gnt_idx  = PW'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    dout_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|req_i) && ready_keccak_i) begin
          gnt_d   = arb_gnt;
          state_d = START;
        end
      end
      START: begin
        lane_cnt_d = '0;
        state_d    = ABSORB;
      end
      ABSORB: begin
        if (lane_cnt_q == 5'(NUM_LANES - 1)) begin
          lane_cnt_d = '0;
          state_d    = LAST;
        end else begin
          lane_cnt_d = lane_cnt_q + 5'd1;
        end
      end
      LAST: state_d = SQUEEZE;
      SQUEEZE: begin
        if (dout_valid_keccak_i) begin
          dout_we = 1'b1;
          if (lane_cnt_q == 5'(NUM_LANES - 1)) begin
            lane_cnt_d = '0;
            state_d    = DONE;
          end else begin
            lane_cnt_d = lane_cnt_q + 5'd1;
          end
        end
      end
      DONE: begin
        rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        gnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NUM_LANES; j++) dout_q[j] <= '0;
    end else if (dout_we) begin
      dout_q[lane_cnt_q] <= dout_keccak_i;
    end
  end

  assign gnt_o               = gnt_q;
  assign done_o              = (state_q == DONE) ? gnt_q : '0;
  assign busy_o              = (state_q != IDLE);
  assign start_keccak_o      = (state_q == START);
  assign din_valid_keccak_o  = (state_q == ABSORB);
  assign last_block_keccak_o = (state_q == LAST);
  assign din_keccak_o        = (state_q == ABSORB) ? sel_lane : '0;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter with a lane-echo core model (lane ^ 0xFF).
module tb_keccak_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [3199:0] din;
  logic [1:0]    gnt, done;
  logic [1599:0] dout;
  logic          busy, ready, start, din_valid, last_blk, dout_v;
  logic [63:0]   din_k, dout_k;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [1599:0] prev_exp;

  keccak_arbiter #(.NUM_REQ(2)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_i               (req),
    .din_i               (din),
    .gnt_o               (gnt),
    .done_o              (done),
    .dout_o              (dout),
    .busy_o              (busy),
    .ready_keccak_i      (ready),
    .start_keccak_o      (start),
    .din_keccak_o        (din_k),
    .din_valid_keccak_o  (din_valid),
    .last_block_keccak_o (last_blk),
    .dout_keccak_i       (dout_k),
    .dout_valid_keccak_i (dout_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] req;
    int         exp_idx;
    bit         rst_before;
    bit         gaps;
    bit         spurious;
    int         drop_lane;
    int         ready_delay;
    int         exp_lat;
    int         abort_lane;
  } vec_t;

  function automatic vec_t mk(logic [1:0] r, int idx, bit rb, bit g, bit sp,
                              int drop, int rd, int lat, int ab);
    vec_t v;
    v.req = r; v.exp_idx = idx; v.rst_before = rb; v.gaps = g; v.spurious = sp;
    v.drop_lane = drop; v.ready_delay = rd; v.exp_lat = lat; v.abort_lane = ab;
    return v;
  endfunction

  function automatic logic [63:0] pat(int k, int j);
    logic [63:0] base;
    base = (k == 0) ? 64'h0101_0101_0000_0000 : 64'h0202_0202_0000_0000;
    return base + 64'(j);
  endfunction

  function automatic logic [1599:0] exp_state(int k);
    logic [1599:0] e;
    for (int j = 0; j < 25; j++) e[64*j +: 64] = pat(k, j) ^ 64'hFF;
    return e;
  endfunction

  function automatic int lane_diffs(logic [1599:0] a, logic [1599:0] b);
    int n = 0;
    for (int j = 0; j < 25; j++) if (a[64*j +: 64] !== b[64*j +: 64]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input bit ok, input longint unsigned act,
                     input longint unsigned expv);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic bit outs_zero();
    return (gnt == 2'b00) && (done == 2'b00) && !busy && !start && !din_valid &&
           !last_blk && (din_k == 64'd0) && (dout == '0);
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = 2'b00;
    dout_v = 1'b0;
    dout_k = '0;
    ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    prev_exp = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int nabs = 0, nstart = 0, nlast = 0, sent = 0;
    int t0, rdy_cyc = 0, absorb_end = -10, lastv_cyc = -10;
    bit sq = 0, tog = 0, spur_done = 0, din_leak = 0, ok_lanes = 1;
    logic [63:0]   got [25];
    logic [1599:0] expd;
    logic [1:0]    exp_oh;
    expd   = exp_state(v.exp_idx);
    exp_oh = (v.exp_idx == 0) ? 2'b01 : 2'b10;
    if (v.rst_before) do_reset();
    req = v.req;
    if (v.ready_delay > 0) begin
      bit quiet = 1;
      ready = 1'b0;
      repeat (v.ready_delay) begin
        @(posedge clk); #1;
        if (start || busy) quiet = 0;
      end
      chk("ready_gate_idle", quiet, {start, busy}, 0);
      ready   = 1'b1;
      rdy_cyc = cyc;
    end
    t0 = cyc;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      dout_v = 1'b0;
      dout_k = '0;
      if (done != 2'b00) begin
        chk("done_onehot", done == exp_oh, done, exp_oh);
        chk("done_after_last_valid", cyc == lastv_cyc + 1, cyc - lastv_cyc, 1);
        chk("dout_result", dout == expd, lane_diffs(dout, expd), 0);
        if (v.exp_lat > 0) chk("latency", cyc - t0 + 1 == v.exp_lat, cyc - t0 + 1, v.exp_lat);
        chk("start_count", nstart == 1, nstart, 1);
        chk("absorb_lanes", (nabs == 25) && ok_lanes, nabs, 25);
        chk("last_count", nlast == 1, nlast, 1);
        chk("din_zero_outside_absorb", !din_leak, din_leak, 0);
        @(posedge clk); #1;
        chk("idle_after_done", !busy && (done == 2'b00) && (gnt == 2'b00), {busy, done, gnt}, 0);
        prev_exp = expd;
        return;
      end
      if (start) begin
        nstart++;
        if (nstart == 1) begin
          chk("grant", gnt == exp_oh, gnt, exp_oh);
          if (v.ready_delay > 0)
            chk("ready_to_start_cycles", cyc - rdy_cyc + 1 == 2, cyc - rdy_cyc + 1, 2);
        end
      end
      if (din_valid) begin
        if (nabs < 25) got[nabs] = din_k;
        if (nabs >= 25 || din_k != pat(v.exp_idx, nabs)) ok_lanes = 0;
        if (nabs == v.drop_lane) req[v.exp_idx] = 1'b0;
        nabs++;
        if (nabs == 25) absorb_end = cyc;
      end else if (din_k != 64'd0) begin
        din_leak = 1;
      end
      if (v.abort_lane >= 0 && sent == v.abort_lane + 1) begin
        bit no_done = 1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_squeeze_zero", outs_zero(), {gnt, done, busy, start, last_blk}, 0);
        repeat (3) begin
          @(posedge clk); #1;
          if (done != 2'b00 || busy) no_done = 0;
        end
        chk("no_done_after_abort", no_done, done, 0);
        req = 2'b00;
        rst_n = 1'b1;
        prev_exp = '0;
        return;
      end
      if (sq && sent < 25) begin
        tog = ~tog;
        if (!v.gaps || tog) begin
          dout_v    = 1'b1;
          dout_k    = got[sent] ^ 64'hFF;
          sent++;
          lastv_cyc = cyc;
        end
      end
      if (v.spurious && nabs == 5 && !spur_done) begin
        dout_v    = 1'b1;
        dout_k    = 64'hDEAD_BEEF_DEAD_BEEF;
        spur_done = 1;
      end
      if (last_blk) begin
        nlast++;
        if (nlast == 1) begin
          chk("last_after_lane24", cyc == absorb_end + 1, cyc - absorb_end, 1);
          chk("dout_held_before_squeeze", dout == prev_exp, lane_diffs(dout, prev_exp), 0);
        end
        sq = 1;
      end
    end
    chk("timeout", 0, cyc, 0);
  endtask

  vec_t tbl [11];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 25; j++) din[k*1600 + 64*j +: 64] = pat(k, j);
    rst_n  = 1'b0;
    req    = 2'b00;
    ready  = 1'b1;
    dout_v = 1'b0;
    dout_k = '0;
    prev_exp = '0;
    #3;
    chk("reset_outputs_zero", outs_zero(), {gnt, done, busy, start, last_blk}, 0);
    req = 2'b11;
    #1;
    chk("reset_ignores_req", outs_zero(), {gnt, busy, start}, 0);

    //          req    idx rst gap spur drop rdy lat abort
    tbl[0]  = mk(2'b01, 0, 1, 0, 0, -1,  0, 54, -1);
    tbl[1]  = mk(2'b11, 0, 1, 0, 0, -1,  0, 54, -1);
    tbl[2]  = mk(2'b11, 1, 0, 0, 0, -1,  0,  0, -1);
    tbl[3]  = mk(2'b11, 0, 0, 0, 0, -1,  0,  0, -1);
    tbl[4]  = mk(2'b11, 1, 0, 0, 0, -1,  0,  0, -1);
    tbl[5]  = mk(2'b10, 1, 0, 0, 0, -1, 10,  0, -1);
    tbl[6]  = mk(2'b01, 0, 0, 1, 1, -1,  0,  0, -1);
    tbl[7]  = mk(2'b11, 1, 0, 0, 0, -1,  0,  0, -1);
    tbl[8]  = mk(2'b01, 0, 0, 0, 0, 10,  0,  0, -1);
    tbl[9]  = mk(2'b01, 0, 1, 0, 0, -1,  0,  0, 12);
    tbl[10] = mk(2'b01, 0, 0, 0, 0, -1,  0, 54, -1);

    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
